ponteh_gate: RTL and testbench
==============================

PONTEH_GATE -- requirements
Module: ponteh_gate

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, with ports CLK and RST_N.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 SH  input  1  clockwise drive request from the H-bridge controller, asynchronous to CLK.
REQ-005 SA  input  1  counter-clockwise drive request from the H-bridge controller, asynchronous to CLK.
REQ-006 DT  input  4  dead time in CLK cycles, unsigned, sampled on entry to DEAD.
REQ-007 FLT_CLR  input  1  fault clear request, level-sensitive.
REQ-008 Q1  output  1  left high-side gate, active-high.
REQ-009 Q2  output  1  left low-side gate, active-high.
REQ-010 Q3  output  1  right high-side gate, active-high.
REQ-011 Q4  output  1  right low-side gate, active-high.
REQ-012 FAULT  output  1  high while in FAULT state.
REQ-013 BUSY  output  1  high while in DEAD state.

Function
REQ-014 SH and SA SHALL each pass through a 2-flop synchroniser; only synchronised values (SHs, SAs) drive the FSM.
REQ-015 Command decode: SHs=1,SAs=0 -> FWD; SHs=0,SAs=1 -> REV; both 0 -> OFF; both 1 -> illegal.
REQ-016 FSM states SHALL be OFF, DEAD, FWD, REV, FAULT, held in a registered state vector.
REQ-017 Outputs SHALL be a Moore decode of the state register: FWD -> Q1=Q4=1, Q2=Q3=0; REV -> Q2=Q3=1, Q1=Q4=0; OFF, DEAD, FAULT -> all Q low.
REQ-018 Q1&Q2 and Q3&Q4 SHALL never be high in the same cycle, under any input sequence.
REQ-019 OFF: decoded FWD or REV -> DEAD, with a dead counter loaded with max(DT,1); decoded OFF -> stay.
REQ-020 FWD or REV: a decoded command differing from the current state -> DEAD on the next edge, counter loaded with max(DT,1); no direct FWD<->REV, FWD/REV->OFF or OFF->FWD/REV transition.
REQ-021 DEAD: the counter decrements each cycle. The target equals the currently decoded command, re-evaluated every cycle without restarting the counter.
REQ-022 At counter=1 in DEAD, the next state SHALL be the target (FWD, REV or OFF). DEAD therefore lasts exactly max(DT,1) cycles.
REQ-023 An illegal decode in any non-FAULT state SHALL force FAULT on the next edge, overriding every other transition.
REQ-024 FAULT: exit to OFF only when FLT_CLR=1 and SHs=SAs=0 in the same cycle; otherwise stay.
REQ-025 A DT change outside DEAD entry SHALL have no effect on a dead interval already in progress.
REQ-026 Latency: a request edge meeting setup before edge k SHALL be visible to the FSM at edge k+2; from OFF, gates assert after edge k+2+max(DT,1).

Reset
REQ-027 RST_N low SHALL immediately force state=OFF, dead counter=0, synchroniser flops=0, and Q1..Q4=0, FAULT=0, BUSY=0, independent of CLK.
REQ-028 Deassertion of RST_N mid-operation SHALL resume from OFF; the first drive request SHALL still pass through a full DEAD interval.

Verification
REQ-029 Reset, DT=3, SH raised before edge 0 -> BUSY=1 after edges 2..4, then Q1=Q4=1 and Q2=Q3=0 from edge 5.
REQ-030 In FWD, DT=2, SH dropped and SA raised together -> all Q low for exactly 2 cycles, then Q2=Q3=1; no cycle with Q1&Q2 or Q3&Q4.
REQ-031 DT=0 with any direction change -> exactly 1 DEAD cycle with all gates low.
REQ-032 SA=SH=1 held 2+ cycles while in REV -> FAULT=1 and all Q low 3 edges after the inputs change; FLT_CLR=1 with the inputs still high -> remain in FAULT; inputs dropped to 0 with FLT_CLR=1 -> OFF on the next edge.
REQ-033 In DEAD (DT=8) with the target FWD, SH dropped at counter=4 -> state goes to OFF when the counter expires, and Q stays low throughout.
REQ-034 RST_N pulsed low asynchronously mid-FWD -> Q1..Q4 go to 0 without waiting for a CLK edge; state=OFF after release.

Source files
------------

// File: rtl/ponteh_gate.sv
// H-bridge gate driver with synchronised direction requests, programmable dead time
// between any gate change, and a latched fault on illegal (both-direction) requests.
module ponteh_gate (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SH,
  input  logic       SA,
  input  logic [3:0] DT,
  input  logic       FLT_CLR,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       Q4,
  output logic       FAULT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DEAD  = 3'd1,
    S_FWD   = 3'd2,
    S_REV   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  state_t     cmd_state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] dt_load;
  logic       sh_p0, sh_p1;
  logic       sa_p0, sa_p1;
  logic       cmd_off;
  logic       cmd_bad;

  // Stage p0/p1: two-flop synchronisers for the asynchronous direction requests
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_p0 <= 1'b0;
      sh_p1 <= 1'b0;
      sa_p0 <= 1'b0;
      sa_p1 <= 1'b0;
    end else begin
      sh_p0 <= SH;
      sh_p1 <= sh_p0;
      sa_p0 <= SA;
      sa_p1 <= sa_p0;
    end
  end

  assign cmd_off = !sh_p1 && !sa_p1;
  assign cmd_bad = sh_p1 && sa_p1;
  assign dt_load = (DT == 4'd0) ? 4'd1 : DT;

  always_comb begin
    cmd_state = S_OFF;
    if (sh_p1 && !sa_p1) cmd_state = S_FWD;
    else if (!sh_p1 && sa_p1) cmd_state = S_REV;
  end

  // Stage p2: control FSM; an illegal request outranks every other transition
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (cmd_bad && state != S_FAULT) begin
      state_nxt = S_FAULT;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        S_OFF: begin
          if (!cmd_off) begin
            state_nxt = S_DEAD;
            cnt_nxt   = dt_load;
          end
        end
        S_FWD, S_REV: begin
          if (cmd_state != state) begin
            state_nxt = S_DEAD;
            cnt_nxt   = dt_load;
          end
        end
        S_DEAD: begin
          // Target follows the live command; only the counter decides when to leave
          if (cnt <= 4'd1) begin
            state_nxt = cmd_state;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        S_FAULT: begin
          if (FLT_CLR && cmd_off) state_nxt = S_OFF;
        end
        default: begin
          state_nxt = S_OFF;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_OFF;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Moore decode straight from the state register, so reset clears gates at once
  always_comb begin
    Q1    = 1'b0;
    Q2    = 1'b0;
    Q3    = 1'b0;
    Q4    = 1'b0;
    FAULT = 1'b0;
    BUSY  = 1'b0;
    case (state)
      S_FWD: begin
        Q1 = 1'b1;
        Q4 = 1'b1;
      end
      S_REV: begin
        Q2 = 1'b1;
        Q3 = 1'b1;
      end
      S_DEAD:  BUSY  = 1'b1;
      S_FAULT: FAULT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ponteh_gate.sv
// Bench for ponteh_gate: fixed vector table, hand-written corner sequences, and a
// randomized run compared against a time-based behavioural model.
module tb_ponteh_gate;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SH, SA, FLT_CLR;
  logic [3:0] DT;
  logic       Q1, Q2, Q3, Q4, FAULT, BUSY;

  int checks = 0;
  int failures = 0;

  ponteh_gate dut (
    .CLK(CLK), .RST_N(RST_N), .SH(SH), .SA(SA), .DT(DT), .FLT_CLR(FLT_CLR),
    .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .FAULT(FAULT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sh;
    logic       sa;
    logic [3:0] dt;
    logic       clr;
    logic [3:0] q;
    logic       fault;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: requests reach the controller two edges late (queue), and a
  // dead interval is an absolute window of edge numbers.
  localparam int M_OFF = 0, M_DEAD = 1, M_FWD = 2, M_REV = 3, M_FAULT = 4;
  logic [1:0] req_q[$];
  int         m_mode;
  int         m_edge;
  int         m_dead_end;

  function automatic logic [5:0] obs();
    return {Q1, Q2, Q3, Q4, FAULT, BUSY};
  endfunction

  function automatic logic [5:0] model_out();
    logic [3:0] g;
    g = (m_mode == M_FWD) ? 4'b1001 : (m_mode == M_REV) ? 4'b0110 : 4'b0000;
    return {g, m_mode == M_FAULT, m_mode == M_DEAD};
  endfunction

  task automatic model_reset();
    req_q = '{2'b00, 2'b00};
    m_mode = M_OFF;
    m_edge = 0;
    m_dead_end = 0;
  endtask

  task automatic model_edge(input logic sh, input logic sa, input logic [3:0] dt,
                            input logic clr);
    logic [1:0] seen;
    int want;
    seen = req_q.pop_front();
    req_q.push_back({sh, sa});
    want = (seen == 2'b10) ? M_FWD : (seen == 2'b01) ? M_REV : M_OFF;
    if (seen == 2'b11) begin
      if (m_mode != M_FAULT) m_mode = M_FAULT;
    end else if (m_mode == M_FAULT) begin
      if (clr && seen == 2'b00) m_mode = M_OFF;
    end else if (m_mode == M_DEAD) begin
      if (m_edge >= m_dead_end) m_mode = want;
    end else if (want != m_mode) begin
      m_mode = M_DEAD;
      m_dead_end = m_edge + ((dt == 0) ? 1 : int'(dt));
    end
    m_edge++;
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b (Q1Q2Q3Q4 FAULT BUSY)", name, got, want);
    end
  endtask

  task automatic do_reset();
    SH = 1'b0; SA = 1'b0; DT = 4'd0; FLT_CLR = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", obs(), 6'b0);
    model_reset();
    RST_N = 1'b1;
  endtask

  task automatic add(input logic sh, input logic sa, input logic [3:0] dt, input logic clr,
                     input logic [3:0] q, input logic fault, input logic busy);
    vec_t v;
    v.sh = sh; v.sa = sa; v.dt = dt; v.clr = clr; v.q = q; v.fault = fault; v.busy = busy;
    vecs.push_back(v);
  endtask

  initial begin
    RST_N = 1'b1; SH = 1'b0; SA = 1'b0; DT = 4'd0; FLT_CLR = 1'b0;
    #2;

    // Forward entry with DT=3: dead after edges 2..4, gates from edge 5
    add(1,0,3,0, 4'b0000,0,0); add(1,0,3,0, 4'b0000,0,0);
    add(1,0,3,0, 4'b0000,0,1); add(1,0,3,0, 4'b0000,0,1); add(1,0,3,0, 4'b0000,0,1);
    add(1,0,3,0, 4'b1001,0,0); add(1,0,3,0, 4'b1001,0,0);
    // Reversal with DT=2
    add(0,1,2,0, 4'b1001,0,0); add(0,1,2,0, 4'b1001,0,0);
    add(0,1,2,0, 4'b0000,0,1); add(0,1,2,0, 4'b0000,0,1);
    add(0,1,2,0, 4'b0110,0,0); add(0,1,2,0, 4'b0110,0,0);
    // DT=0 gives a single dead cycle
    add(1,0,0,0, 4'b0110,0,0); add(1,0,0,0, 4'b0110,0,0);
    add(1,0,0,0, 4'b0000,0,1); add(1,0,0,0, 4'b1001,0,0); add(1,0,0,0, 4'b1001,0,0);
    // Back to REV, then both requests high
    add(0,1,1,0, 4'b1001,0,0); add(0,1,1,0, 4'b1001,0,0);
    add(0,1,1,0, 4'b0000,0,1); add(0,1,1,0, 4'b0110,0,0); add(0,1,1,0, 4'b0110,0,0);
    add(1,1,1,0, 4'b0110,0,0); add(1,1,1,0, 4'b0110,0,0);
    add(1,1,1,0, 4'b0000,1,0); add(1,1,1,0, 4'b0000,1,0);
    // Clear with requests still high is ignored; clear with requests low exits
    add(1,1,1,1, 4'b0000,1,0); add(1,1,1,1, 4'b0000,1,0);
    add(0,0,1,1, 4'b0000,1,0); add(0,0,1,1, 4'b0000,1,0);
    add(0,0,1,1, 4'b0000,0,0); add(0,0,1,0, 4'b0000,0,0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      SH = vecs[i].sh; SA = vecs[i].sa; DT = vecs[i].dt; FLT_CLR = vecs[i].clr;
      @(posedge CLK);
      #1;
      check($sformatf("table_edge%0d", i), obs(),
            {vecs[i].q, vecs[i].fault, vecs[i].busy});
    end

    // Target withdrawn mid-dead with DT=8; DT change mid-interval has no effect
    SH = 1'b1; SA = 1'b0; DT = 4'd8; FLT_CLR = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      if (e == 4) begin
        SH = 1'b0;
        DT = 4'd1;
      end
      @(posedge CLK);
      #1;
      check($sformatf("withdraw_edge%0d", e), obs(),
            {4'b0000, 1'b0, (e >= 2 && e <= 9) ? 1'b1 : 1'b0});
    end

    // Asynchronous reset in FWD, then a full dead interval after release
    SH = 1'b1; DT = 4'd2;
    repeat (6) @(posedge CLK);
    #1;
    check("pre_reset_fwd", obs(), 6'b100100);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_gates", obs(), 6'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(posedge CLK);
      #1;
      if (e == 1) check("post_reset_off", obs(), 6'b000000);
      if (e == 2) check("post_reset_dead", obs(), 6'b000001);
      if (e == 4) check("post_reset_fwd", obs(), 6'b100100);
    end

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(0, 19);
        if (k < 6) begin SH = 1'b1; SA = 1'b0; end
        else if (k < 12) begin SH = 1'b0; SA = 1'b1; end
        else if (k < 18) begin SH = 1'b0; SA = 1'b0; end
        else begin SH = 1'b1; SA = 1'b1; end
      end
      if ($urandom_range(0, 7) == 0) DT = 4'($urandom_range(0, 15));
      FLT_CLR = ($urandom_range(0, 3) == 0);
      @(posedge CLK);
      model_edge(SH, SA, DT, FLT_CLR);
      #1;
      check($sformatf("random_cycle%0d", c), obs(), model_out());
      check($sformatf("overlap_cycle%0d", c), {5'b0, (Q1 & Q2) | (Q3 & Q4)}, 6'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
